// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the fetch PC, issues credit-limited in-order requests to
// instruction memory, pushes responses into the instruction buffer and drains stale responses after a redirect.
module fetch_sequencer #(
    parameter int ADDR_WIDTH      = 32,
    parameter int INST_WIDTH      = 32,
    parameter int BUFFER_DEPTH    = 8,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 stall,
    input  logic                                 redirect_valid,
    input  logic [ADDR_WIDTH-1:0]                redirect_pc,
    output logic                                 imem_req_valid,
    output logic [ADDR_WIDTH-1:0]                imem_req_addr,
    input  logic                                 imem_req_ready,
    input  logic                                 imem_resp_valid,
    input  logic [INST_WIDTH-1:0]                imem_resp_data,
    output logic                                 buf_write_en,
    output logic [INST_WIDTH-1:0]                buf_data_in,
    output logic                                 buf_read_en,
    output logic                                 buf_flush,
    output logic [$clog2(BUFFER_DEPTH):0]        occupancy,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
    output logic                                 draining
);

    localparam int OCC_W = $clog2(BUFFER_DEPTH) + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [OCC_W-1:0]        r_occ;
    logic [OUT_W-1:0]        r_outs;
    logic [OUT_W-1:0]        w_outsNext;
    logic                    w_redirect;
    logic                    w_accept;
    logic                    w_resp;
    int                      w_fill;

    // Redirects only count once the sequencer has left IDLE.
    assign w_redirect = redirect_valid & (r_state != IDLE);
    assign w_fill     = int'(r_occ) + int'(r_outs);
    assign w_accept   = imem_req_valid & imem_req_ready;
    assign w_resp     = imem_resp_valid & (r_outs != '0);

    always_comb begin
        w_outsNext = r_outs;
        if (w_accept && !w_resp) begin
            w_outsNext = r_outs + OUT_W'(1);
        end else if (!w_accept && w_resp) begin
            w_outsNext = r_outs - OUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    w_nextState = RUN;
            RUN:     if (w_redirect && (w_outsNext != '0)) w_nextState = DRAIN;
            DRAIN:   if ((r_outs == '0) && !redirect_valid) w_nextState = RUN;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        buf_write_en   = 1'b0;
        buf_read_en    = 1'b0;
        buf_flush      = 1'b0;
        draining       = 1'b0;
        if (r_state == RUN) begin
            imem_req_valid = !redirect_valid && (w_fill < BUFFER_DEPTH)
                             && (int'(r_outs) < MAX_OUTSTANDING);
            buf_write_en   = w_resp && !redirect_valid;
        end
        if (r_state != IDLE) begin
            buf_read_en = !stall && !redirect_valid && (r_occ != '0);
            buf_flush   = redirect_valid;
        end
        draining = (r_state == DRAIN);
    end

    assign imem_req_addr = r_pc;
    assign buf_data_in   = imem_resp_data;
    assign occupancy     = r_occ;
    assign outstanding   = r_outs;

    // Flush wins over any push/pop; otherwise a simultaneous push and pop cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc   <= RESET_PC;
            r_occ  <= '0;
            r_outs <= '0;
        end else begin
            r_outs <= w_outsNext;
            if (w_redirect) begin
                r_pc  <= redirect_pc;
                r_occ <= '0;
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + ADDR_WIDTH'(4);
                end
                if (buf_write_en && !buf_read_en) begin
                    r_occ <= r_occ + OCC_W'(1);
                end else if (!buf_write_en && buf_read_en) begin
                    r_occ <= r_occ - OCC_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a cycle table with a data scoreboard,
// followed by hand-written sequences for the full, redirect, drain and reset corner cases.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        buf_write_en;
    logic [31:0] buf_data_in;
    logic        buf_read_en;
    logic        buf_flush;
    logic [3:0]  occupancy;
    logic [1:0]  outstanding;
    logic        draining;

    int checks = 0;
    int errors = 0;
    logic [31:0] sbq[$];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .buf_write_en(buf_write_en),
        .buf_data_in(buf_data_in), .buf_read_en(buf_read_en), .buf_flush(buf_flush),
        .occupancy(occupancy), .outstanding(outstanding), .draining(draining)
    );

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        rv;
        logic [31:0] rdata;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expWe;
        logic        expRe;
        logic        expFlush;
        int          expOcc;
        int          expOuts;
        logic        expDrain;
    } vec_t;

    vec_t vec[14];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc,
                                 input logic rdy, input logic rv, input logic [31:0] rd);
        stall           = s;
        redirect_valid  = r;
        redirect_pc     = rpc;
        imem_req_ready  = rdy;
        imem_resp_valid = rv;
        imem_resp_data  = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sbObserve(input string tag);
        if (buf_write_en === 1'b1) begin
            if (sbq.size() == 0) begin
                checkOutput({tag, " unexpected push"}, 32'(buf_write_en), 32'd0);
            end else begin
                checkOutput({tag, " buf_data_in"}, buf_data_in, sbq.pop_front());
            end
        end
    endtask

    // Holds reset across two edges and releases it just after an edge, leaving the DUT in its IDLE cycle.
    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic        pend;
        logic [31:0] pendAddr;
        int          pushes;

        vec[0]  = '{0,1,32'h500,1,0,0,            0,32'h000,0,0,0,0,0,0};
        vec[1]  = '{0,0,0,1,0,0,                  1,32'h000,0,0,0,0,0,0};
        vec[2]  = '{0,0,0,1,1,32'h1111_0002,      1,32'h004,1,0,0,0,1,0};
        vec[3]  = '{0,0,0,1,1,32'h1111_0003,      1,32'h008,1,1,0,1,1,0};
        vec[4]  = '{0,0,0,0,1,32'h1111_0004,      1,32'h00C,1,1,0,1,1,0};
        vec[5]  = '{1,0,0,1,0,0,                  1,32'h00C,0,0,0,1,0,0};
        vec[6]  = '{1,0,0,1,0,0,                  1,32'h010,0,0,0,1,1,0};
        vec[7]  = '{1,0,0,1,0,0,                  0,32'h014,0,0,0,1,2,0};
        vec[8]  = '{0,1,32'h100,1,1,32'h1111_0008,0,32'h014,0,0,1,1,2,0};
        vec[9]  = '{0,0,0,1,1,32'h1111_0009,      0,32'h100,0,0,0,0,1,1};
        vec[10] = '{0,0,0,1,0,0,                  0,32'h100,0,0,0,0,0,1};
        vec[11] = '{0,0,0,1,0,0,                  1,32'h100,0,0,0,0,0,0};
        vec[12] = '{0,0,0,0,1,32'h1111_000C,      1,32'h104,1,0,0,0,1,0};
        vec[13] = '{0,0,0,0,0,0,                  1,32'h104,0,1,0,1,0,0};

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h700, 1'b1, 1'b1, 32'hDEAD);
        #3;
        checkOutput("reset req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("reset flush", 32'(buf_flush), 32'd0);
        checkOutput("reset write_en", 32'(buf_write_en), 32'd0);
        checkOutput("reset occupancy", 32'(occupancy), 32'd0);
        checkOutput("reset outstanding", 32'(outstanding), 32'd0);

        doReset();
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vec[i].stall, vec[i].redir, vec[i].rpc, vec[i].ready, vec[i].rv, vec[i].rdata);
            if (vec[i].expWe) sbq.push_back(vec[i].rdata);
            #2;
            checkOutput($sformatf("row%0d req_valid", i), 32'(imem_req_valid), 32'(vec[i].expReq));
            checkOutput($sformatf("row%0d req_addr", i), imem_req_addr, vec[i].expAddr);
            checkOutput($sformatf("row%0d write_en", i), 32'(buf_write_en), 32'(vec[i].expWe));
            checkOutput($sformatf("row%0d read_en", i), 32'(buf_read_en), 32'(vec[i].expRe));
            checkOutput($sformatf("row%0d flush", i), 32'(buf_flush), 32'(vec[i].expFlush));
            checkOutput($sformatf("row%0d occupancy", i), 32'(occupancy), 32'(vec[i].expOcc));
            checkOutput($sformatf("row%0d outstanding", i), 32'(outstanding), 32'(vec[i].expOuts));
            checkOutput($sformatf("row%0d draining", i), 32'(draining), 32'(vec[i].expDrain));
            sbObserve($sformatf("row%0d", i));
            step();
        end

        // Fill the buffer under stall with a one-cycle-latency memory.
        doReset();
        pend = 1'b0;
        pendAddr = '0;
        pushes = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, pend, pendAddr ^ 32'hC0DE_0000);
            if (pend) sbq.push_back(pendAddr ^ 32'hC0DE_0000);
            #2;
            if (buf_write_en) pushes++;
            checkOutput($sformatf("full c%0d credit", c), 32'((int'(occupancy) + int'(outstanding)) <= 8), 32'd1);
            sbObserve("full");
            pend = imem_req_valid & imem_req_ready;
            pendAddr = imem_req_addr;
            step();
        end
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        #2;
        checkOutput("full pushes", 32'(pushes), 32'd8);
        checkOutput("full occupancy", 32'(occupancy), 32'd8);
        checkOutput("full outstanding", 32'(outstanding), 32'd0);
        checkOutput("full req_valid", 32'(imem_req_valid), 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        #2;
        checkOutput("release read_en", 32'(buf_read_en), 32'd1);
        checkOutput("release req_valid same cycle", 32'(imem_req_valid), 32'd0);
        step();
        #2;
        checkOutput("release req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("release req_addr", imem_req_addr, 32'h20);
        checkOutput("release occupancy", 32'(occupancy), 32'd7);

        // Response and redirect in the same cycle with one request in flight.
        doReset();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        step();
        #2;
        checkOutput("samecyc first addr", imem_req_addr, 32'h0);
        step();
        applyStimulus(1'b0, 1'b1, 32'h300, 1'b1, 1'b1, 32'hBAD0_0001);
        #2;
        checkOutput("samecyc outstanding before", 32'(outstanding), 32'd1);
        checkOutput("samecyc write_en", 32'(buf_write_en), 32'd0);
        checkOutput("samecyc flush", 32'(buf_flush), 32'd1);
        checkOutput("samecyc req_valid", 32'(imem_req_valid), 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        #2;
        checkOutput("samecyc outstanding", 32'(outstanding), 32'd0);
        checkOutput("samecyc draining", 32'(draining), 32'd0);
        checkOutput("samecyc req_valid after", 32'(imem_req_valid), 32'd1);
        checkOutput("samecyc req_addr", imem_req_addr, 32'h300);

        // Second redirect while draining must win.
        doReset();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        step();
        step();
        step();
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'd0);
        #2;
        checkOutput("drain2 outstanding", 32'(outstanding), 32'd2);
        checkOutput("drain2 flush", 32'(buf_flush), 32'd1);
        step();
        applyStimulus(1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 32'hBAD0_0002);
        #2;
        checkOutput("drain2 draining", 32'(draining), 32'd1);
        checkOutput("drain2 second flush", 32'(buf_flush), 32'd1);
        checkOutput("drain2 write_en a", 32'(buf_write_en), 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hBAD0_0003);
        #2;
        checkOutput("drain2 still draining", 32'(draining), 32'd1);
        checkOutput("drain2 outstanding mid", 32'(outstanding), 32'd1);
        checkOutput("drain2 write_en b", 32'(buf_write_en), 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        #2;
        for (int k = 0; k < 8 && !imem_req_valid; k++) begin
            step();
            #2;
        end
        checkOutput("drain2 req_valid within bound", 32'(imem_req_valid), 32'd1);
        checkOutput("drain2 req_addr", imem_req_addr, 32'h200);

        // Asynchronous reset in the middle of traffic.
        doReset();
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        step();
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, (c >= 2 && c <= 6), 32'h5500_0000 + 32'(c));
            if (c >= 2 && c <= 6) sbq.push_back(32'h5500_0000 + 32'(c));
            #2;
            sbObserve("midrst");
            step();
        end
        #2;
        checkOutput("midrst occupancy before", 32'(occupancy), 32'd5);
        checkOutput("midrst outstanding before", 32'(outstanding), 32'd2);
        rst_n = 1'b0;
        imem_resp_valid = 1'b1;
        #1;
        checkOutput("midrst occupancy", 32'(occupancy), 32'd0);
        checkOutput("midrst outstanding", 32'(outstanding), 32'd0);
        checkOutput("midrst req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("midrst write_en", 32'(buf_write_en), 32'd0);
        step();
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hBAD0_0004);
        #2;
        checkOutput("midrst idle req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("midrst idle write_en", 32'(buf_write_en), 32'd0);
        step();
        #2;
        checkOutput("midrst run req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("midrst run req_addr", imem_req_addr, 32'h0);
        checkOutput("midrst stray write_en", 32'(buf_write_en), 32'd0);
        step();
        #2;
        checkOutput("midrst stray outstanding", 32'(outstanding), 32'd0);

        checkOutput("scoreboard empty", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
